// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcode and ALU encodings,
// FSM state and instruction-class enumerations.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALU_W    = 4;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_LD,
        CLS_LDI,
        CLS_ST,
        CLS_RTYPE,
        CLS_IMM,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_t;

    // Classes whose execute sequence finishes in T5 (register writeback there).
    function automatic logic ends_at_t5(input instr_class_t cls);
        return (cls == CLS_LDI) || (cls == CLS_RTYPE) || (cls == CLS_IMM);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master: control unit (drives strobes/alu_op/run/illegal, reads ir/mem_ready)
//   slave : datapath/memory side (drives ir/mem_ready, reads strobes)
interface control_unit_if #(
    parameter int ALU_OPW = 4
);
    logic [31:0]        ir;
    logic               mem_ready;

    logic               PCout, Zlowout, MDRout;
    logic               Rout, BAout, Csignout;
    logic               MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin;
    logic               Gra, Grb, Grc;
    logic               IncPC;
    logic               Read, Write, MD_read;
    logic [ALU_OPW-1:0] alu_op;
    logic               run;
    logic               illegal;

    modport master (
        input  ir, mem_ready,
        output PCout, Zlowout, MDRout, Rout, BAout, Csignout,
               MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin,
               Gra, Grb, Grc, IncPC, Read, Write, MD_read,
               alu_op, run, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, Zlowout, MDRout, Rout, BAout, Csignout,
               MARin, PCin, MDRin, IRin, Yin, Zlowin, Rin,
               Gra, Grb, Grc, IncPC, Read, Write, MD_read,
               alu_op, run, illegal
    );
endinterface

// File: rtl/control_unit_ctrl_decode.sv
// ctrl_decode: combinational opcode -> instruction class and ALU select.
//   opcode : ir[31:27]
//   cls    : instruction class steering the execute steps
//   alu_op : ALU operation used in T4 (ADD for address/undefined forms)
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW     = OPCODE_W,
    parameter int ALU_OPW = ALU_W
) (
    input  logic [OPW-1:0]     opcode,
    output instr_class_t       cls,
    output logic [ALU_OPW-1:0] alu_op
);

    always_comb begin
        cls    = CLS_ILLEGAL;
        alu_op = ALU_ADD;
        case (opcode)
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_ADD:  cls = CLS_RTYPE;
            OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_ADDI: cls = CLS_IMM;
            OP_ANDI: begin cls = CLS_IMM; alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM; alu_op = ALU_OR;  end
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the single-bus datapath.
//   clock  : rising-edge system clock
//   clear  : synchronous active-high reset to RESET
//   bus    : control_unit_if.master -- ir and mem_ready in; bus drivers,
//            load enables, register selects, memory strobes, alu_op,
//            run and illegal out
// Steps: T0-T2 fetch, T3 decode, T4-T7 execute; T1, ld-T6 and st-T7 stall
// until mem_ready. Operand fields of ir are consumed by the datapath's
// select/encode logic; only the opcode is used here.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW     = OPCODE_W,
    parameter int ALU_OPW = ALU_W
) (
    input  logic          clock,
    input  logic          clear,
    control_unit_if.master bus
);

    state_t               state, next_state;
    instr_class_t         cls;
    logic [ALU_OPW-1:0]   dec_alu;

    ctrl_decode #(
        .OPW     (OPW),
        .ALU_OPW (ALU_OPW)
    ) u_decode (
        .opcode (bus.ir[31 -: OPW]),
        .cls    (cls),
        .alu_op (dec_alu)
    );

    always_ff @(posedge clock) begin
        if (clear) state <= S_RESET;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    if (bus.mem_ready) next_state = S_T2;
            S_T2:    next_state = S_T3;
            S_T3: begin
                case (cls)
                    CLS_HALT:             next_state = S_HALT;
                    CLS_NOP, CLS_ILLEGAL: next_state = S_T0;
                    default:              next_state = S_T4;
                endcase
            end
            S_T4:    next_state = S_T5;
            S_T5:    next_state = ends_at_t5(cls) ? S_T0 : S_T6;
            // ld reads memory in T6; st only loads MDR from the register there.
            S_T6: begin
                if (cls != CLS_LD || bus.mem_ready) next_state = S_T7;
            end
            // st writes memory in T7; ld only writes back the register there.
            S_T7: begin
                if (cls != CLS_ST || bus.mem_ready) next_state = S_T0;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Rout     = 1'b0;
        bus.BAout    = 1'b0;
        bus.Csignout = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Rin      = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Write    = 1'b0;
        bus.MD_read  = 1'b0;
        bus.alu_op   = '0;
        bus.illegal  = 1'b0;
        bus.run      = (state != S_RESET) && (state != S_HALT);

        case (state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MD_read = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        bus.Grb   = 1'b1;
                        bus.BAout = 1'b1;
                        bus.Yin   = 1'b1;
                    end
                    CLS_RTYPE, CLS_IMM: begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                    CLS_ILLEGAL: bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                bus.Zlowin = 1'b1;
                bus.alu_op = dec_alu;
                if (cls == CLS_RTYPE) begin
                    bus.Grc  = 1'b1;
                    bus.Rout = 1'b1;
                end else begin
                    bus.Csignout = 1'b1;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (ends_at_t5(cls)) begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end else begin
                    bus.MARin = 1'b1;
                end
            end
            S_T6: begin
                bus.MDRin = 1'b1;
                if (cls == CLS_LD) begin
                    bus.Read    = 1'b1;
                    bus.MD_read = 1'b1;
                end else begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                end
            end
            S_T7: begin
                if (cls == CLS_LD) begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end else begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic clock;
    logic clear;
    int   total;
    int   bad;

    control_unit_if bus ();

    control_unit u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observation vector: {run, illegal, alu_op[3:0], strobes[19:0]}
    localparam logic [25:0] B_PCOUT   = 26'd1 << 0;
    localparam logic [25:0] B_ZLOWOUT = 26'd1 << 1;
    localparam logic [25:0] B_MDROUT  = 26'd1 << 2;
    localparam logic [25:0] B_ROUT    = 26'd1 << 3;
    localparam logic [25:0] B_BAOUT   = 26'd1 << 4;
    localparam logic [25:0] B_CSIGN   = 26'd1 << 5;
    localparam logic [25:0] B_MARIN   = 26'd1 << 6;
    localparam logic [25:0] B_PCIN    = 26'd1 << 7;
    localparam logic [25:0] B_MDRIN   = 26'd1 << 8;
    localparam logic [25:0] B_IRIN    = 26'd1 << 9;
    localparam logic [25:0] B_YIN     = 26'd1 << 10;
    localparam logic [25:0] B_ZLOWIN  = 26'd1 << 11;
    localparam logic [25:0] B_RIN     = 26'd1 << 12;
    localparam logic [25:0] B_GRA     = 26'd1 << 13;
    localparam logic [25:0] B_GRB     = 26'd1 << 14;
    localparam logic [25:0] B_GRC     = 26'd1 << 15;
    localparam logic [25:0] B_INCPC   = 26'd1 << 16;
    localparam logic [25:0] B_READ    = 26'd1 << 17;
    localparam logic [25:0] B_WRITE   = 26'd1 << 18;
    localparam logic [25:0] B_MDREAD  = 26'd1 << 19;
    localparam logic [25:0] B_ILL     = 26'd1 << 24;
    localparam logic [25:0] B_RUN     = 26'd1 << 25;

    localparam logic [25:0] V_IDLE = '0;
    localparam logic [25:0] V_T0 = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
    localparam logic [25:0] V_T1 = B_RUN | B_ZLOWOUT | B_PCIN | B_READ | B_MDREAD | B_MDRIN;
    localparam logic [25:0] V_T2 = B_RUN | B_MDROUT | B_IRIN;
    localparam logic [25:0] V_MEM_T3 = B_RUN | B_GRB | B_BAOUT | B_YIN;
    localparam logic [25:0] V_MEM_T4 = B_RUN | B_CSIGN | B_ZLOWIN;
    localparam logic [25:0] V_ADR_T5 = B_RUN | B_ZLOWOUT | B_MARIN;
    localparam logic [25:0] V_LD_T6  = B_RUN | B_READ | B_MDREAD | B_MDRIN;
    localparam logic [25:0] V_LD_T7  = B_RUN | B_MDROUT | B_GRA | B_RIN;
    localparam logic [25:0] V_ST_T6  = B_RUN | B_GRA | B_ROUT | B_MDRIN;
    localparam logic [25:0] V_ST_T7  = B_RUN | B_WRITE;
    localparam logic [25:0] V_R_T3   = B_RUN | B_GRB | B_ROUT | B_YIN;
    localparam logic [25:0] V_R_T4   = B_RUN | B_GRC | B_ROUT | B_ZLOWIN;
    localparam logic [25:0] V_I_T4   = B_RUN | B_CSIGN | B_ZLOWIN;
    localparam logic [25:0] V_WB_T5  = B_RUN | B_ZLOWOUT | B_GRA | B_RIN;

    function automatic logic [25:0] alu(input int unsigned code);
        logic [25:0] v;
        v = '0;
        v[23:20] = code[3:0];
        return v;
    endfunction

    function automatic logic [25:0] observe();
        return {bus.run, bus.illegal, bus.alu_op,
                bus.MD_read, bus.Write, bus.Read, bus.IncPC,
                bus.Grc, bus.Grb, bus.Gra, bus.Rin, bus.Zlowin, bus.Yin,
                bus.IRin, bus.MDRin, bus.PCin, bus.MARin, bus.Csignout,
                bus.BAout, bus.Rout, bus.MDRout, bus.Zlowout, bus.PCout};
    endfunction

    task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check the current cycle's outputs, then advance.
    task automatic expect_step(input string tag, input logic [25:0] exp);
        check(tag, observe(), exp);
        step();
    endtask

    task automatic fetch(input string tag);
        expect_step({tag, "_t0"}, V_T0);
        expect_step({tag, "_t1"}, V_T1);
        expect_step({tag, "_t2"}, V_T2);
    endtask

    task automatic rtype(input string tag, input logic [31:0] ir, input int unsigned code);
        bus.ir = ir;
        fetch(tag);
        expect_step({tag, "_t3"}, V_R_T3);
        expect_step({tag, "_t4"}, V_R_T4 | alu(code));
        expect_step({tag, "_t5"}, V_WB_T5);
    endtask

    task automatic imm(input string tag, input logic [31:0] ir, input int unsigned code);
        bus.ir = ir;
        fetch(tag);
        expect_step({tag, "_t3"}, V_R_T3);
        expect_step({tag, "_t4"}, V_I_T4 | alu(code));
        expect_step({tag, "_t5"}, V_WB_T5);
    endtask

    initial begin
        total = 0;
        bad = 0;
        clear = 1'b1;
        bus.ir = 32'h0;
        bus.mem_ready = 1'b1;
        step();
        step();
        check("reset", observe(), V_IDLE);

        // Leave reset: first edge with clear low enters T0.
        clear = 1'b0;
        step();

        // ld R1,0x55(R0)
        bus.ir = 32'h00800055;
        fetch("ld");
        expect_step("ld_t3", V_MEM_T3);
        expect_step("ld_t4", V_MEM_T4);
        expect_step("ld_t5", V_ADR_T5);
        expect_step("ld_t6", V_LD_T6);
        expect_step("ld_t7", V_LD_T7);

        // R-type and immediate forms, each six cycles back to T0.
        rtype("add", 32'h18918000, 0);
        rtype("sub", 32'h20918000, 1);
        rtype("or",  32'h58918000, 3);
        imm("andi", 32'h68900007, 2);

        // ldi: address computation then writeback in T5.
        bus.ir = 32'h08800012;
        fetch("ldi");
        expect_step("ldi_t3", V_MEM_T3);
        expect_step("ldi_t4", V_MEM_T4);
        expect_step("ldi_t5", V_WB_T5);

        // Fetch stall: mem_ready low for three edges in T1; ignored in T0.
        bus.ir = 32'hD0000000;
        bus.mem_ready = 1'b0;
        expect_step("stall_t0", V_T0);
        expect_step("stall_t1a", V_T1);
        expect_step("stall_t1b", V_T1);
        expect_step("stall_t1c", V_T1);
        check("stall_t1d", observe(), V_T1);
        bus.mem_ready = 1'b1;
        step();
        expect_step("stall_t2", V_T2);
        expect_step("nop_t3", B_RUN);

        // st with Write stalled for three edges in T7.
        bus.ir = 32'h10800010;
        fetch("st");
        expect_step("st_t3", V_MEM_T3);
        expect_step("st_t4", V_MEM_T4);
        expect_step("st_t5", V_ADR_T5);
        bus.mem_ready = 1'b0;
        expect_step("st_t6", V_ST_T6);
        expect_step("st_t7a", V_ST_T7);
        expect_step("st_t7b", V_ST_T7);
        expect_step("st_t7c", V_ST_T7);
        check("st_t7d", observe(), V_ST_T7);
        bus.mem_ready = 1'b1;
        step();

        // Undefined opcode: single illegal pulse in T3, then fetch.
        bus.ir = 32'hF8000000;
        fetch("ill");
        expect_step("ill_t3", B_RUN | B_ILL);
        check("ill_next", observe(), V_T0);

        // clear during T4 of add aborts the instruction.
        bus.ir = 32'h18918000;
        fetch("abort");
        expect_step("abort_t3", V_R_T3);
        check("abort_t4", observe(), V_R_T4);
        clear = 1'b1;
        step();
        check("abort_reset", observe(), V_IDLE);
        clear = 1'b0;
        step();
        check("abort_restart", observe(), V_T0);
        step();

        // clear and mem_ready together while waiting in T1: clear wins.
        check("race_t1", observe(), V_T1);
        clear = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        check("race_reset", observe(), V_IDLE);
        clear = 1'b0;
        step();

        // halt: outputs stay zero until clear, regardless of mem_ready.
        bus.ir = 32'hD8000000;
        fetch("halt");
        expect_step("halt_t3", B_RUN);
        for (int i = 0; i < 22; i++) begin
            bus.mem_ready = i[0];
            check("halt_hold", observe(), V_IDLE);
            step();
        end
        bus.mem_ready = 1'b1;
        clear = 1'b1;
        step();
        check("halt_reset", observe(), V_IDLE);
        clear = 1'b0;
        step();
        check("halt_restart", observe(), V_T0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
